// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with hardwired r0, self-clear after reset and optional write bypass
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NR_RD      = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [NR_RD*ADDR_WIDTH-1:0]      raddr,
  output logic [NR_RD*DATA_WIDTH-1:0]      rdata,
  input  logic [ADDR_WIDTH-1:0]            dbg_raddr,
  output logic [DATA_WIDTH-1:0]            dbg_rdata,
  output logic                             ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    ready_q;
  logic                    run;

  // Entry 0 has no storage; index 0 is masked on every read path.
  logic [DATA_WIDTH-1:0]   rf [1:DEPTH-1];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  assign run   = (state_q == RUN);
  assign ready = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= ONE_IDX;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE_IDX;
          end
        end
        RUN: begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= ONE_IDX;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // The clear sweep owns the write port; external writes only land in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = waddr;
    mem_wdata = wdata;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
      end else if (wen && (waddr != '0)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      rf[mem_addr] <= mem_wdata;
    end
  end

  for (genvar g = 0; g < NR_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;
    assign ra  = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit = (BYPASS != 0) && run && wen && (waddr == ra);
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] =
      (!run || (ra == '0)) ? '0 : (hit ? wdata : rf[ra]);
  end

  assign dbg_rdata = (!run || (dbg_raddr == '0)) ? '0 : rf[dbg_raddr];

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the NPC core. Successor to the single-read-port file: configurable width, depth and read-port count, hardwired-zero register 0, and optional write-to-read bypass. After reset it runs a self-clear sequence that zeroes every entry, and only then asserts `ready`. The decode stage reads operands from it, the writeback stage writes to it, and the difftest/debug logic observes it through a dedicated port.

## Interface
- `ADDR_WIDTH`, default 5: register index width; `DEPTH = 2**ADDR_WIDTH` entries.
- `DATA_WIDTH`, default 64: register width.
- `NR_RD`, default 2: number of operand read ports, ≥1.
- `BYPASS`, default 1: 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value only.

- `clk`  in  1  clock; single clock domain, all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wen`  in  1  write enable.
- `waddr`  in  ADDR_WIDTH  write index.
- `wdata`  in  DATA_WIDTH  write data.
- `raddr`  in  NR_RD*ADDR_WIDTH  packed read indices; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `rdata`  out  NR_RD*DATA_WIDTH  packed read data, same packing as `raddr`.
- `dbg_raddr`  in  ADDR_WIDTH  debug read index.
- `dbg_rdata`  out  DATA_WIDTH  debug read data; never bypassed.
- `ready`  out  1  1 = clear sequence done and the file is accepting writes.

## Operation
- Two-state FSM: CLEAR, RUN.
- Reset: any cycle with `rst=1` puts the FSM in CLEAR and loads the clear counter `cnt` with 1.
- CLEAR, each cycle:
  - Write 0 to `rf[cnt]`, then increment `cnt`.
  - When `cnt == DEPTH-1` is written, move to RUN on the next edge.
  - External `wen` is ignored.
  - All `rdata` and `dbg_rdata` read as 0.
- RUN:
  - If `wen=1` and `waddr != 0`, `rf[waddr] <= wdata`.
  - A write to index 0 is dropped.
- Register 0 holds no storage; every read of index 0 returns 0 on all ports and in all modes.
- Read port i, combinational: `rdata_i = 0` if `raddr_i == 0`. Otherwise, if `BYPASS=1`, RUN, `wen=1` and `waddr == raddr_i`, `rdata_i = wdata`. Otherwise `rdata_i = rf[raddr_i]`.
- Read ports are independent; several ports may address the same index.
- `dbg_rdata = rf[dbg_raddr]` (0 for index 0), reflecting only committed state.
- `rst` asserted during CLEAR restarts the clear from `cnt=1`.
- `rst` asserted during RUN discards any same-cycle write and begins a new clear.
- `cnt` is ADDR_WIDTH bits wide and never wraps; the CLEAR→RUN transition happens before `cnt` could overflow.

## Timing
- Reset values: `ready=0`, all `rdata`=0, `dbg_rdata`=0, FSM=CLEAR.
- Clear latency: DEPTH-1 cycles after the last `rst=1` cycle. `ready` rises at the edge that completes entry DEPTH-1 (cycle DEPTH-1 after `rst` drops, counting the first non-reset cycle as 1).
- `ready` stays 1 until the next `rst`.
- Write latency: data written at edge N appears on a non-bypassed read in cycle N+1. With `BYPASS=1` it also appears in the same cycle as the write, from RUN only.
- Reads have zero-cycle combinational latency; no read handshake.
- Writes are fire-and-forget; the writer must hold off until `ready=1`, and writes with `ready=0` are lost by design.

## Test plan
- Reset then clear: preload garbage by writing 0xDEAD to r5, pulse `rst` 1 cycle. `ready` goes 0, returns 1 exactly 31 cycles later (defaults); r5 reads 0; r31 reads 0.
- Zero register: in RUN, write 0x1234 to index 0. Both ports and `dbg` read 0 for index 0, same cycle and all later cycles.
- Bypass: `BYPASS=1`, write 0xAAAA to r3 while port 0 and port 1 both read r3. Both see 0xAAAA that cycle; `dbg_rdata` for r3 shows the old value, then 0xAAAA next cycle. With `BYPASS=0`, ports show the old value in the write cycle.
- Write during CLEAR: assert `wen` with r7=0x55 at clear cycle 3. After `ready`, r7 reads 0.
- Reset mid-clear: reassert `rst` at clear cycle 10. `ready` rises 31 cycles after the second reset releases, not the first.
- Parameter sweep: `ADDR_WIDTH=4`, `DATA_WIDTH=32`, `NR_RD=3`. `ready` after 15 cycles; write distinct values to r1..r15 and read them back on all 3 ports with distinct addresses per cycle.
